// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution job scheduler.
package conv_pkg;

    localparam int unsigned DIM_W = 4;

    typedef enum logic [1:0] {StIdle, StClear, StRun, StResp} state_e;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DIM = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    // A 3x3 kernel needs at least 3 rows/cols; the engine caps both at max_dim.
    function automatic logic dim_legal(input logic [DIM_W-1:0] d, input int unsigned max_dim);
        return (32'(d) >= 32'd3) && (32'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/conv_job_sched_if.sv
// Requester and engine signals of the scheduler; slave is the scheduler side.
interface conv_job_sched_if
    import conv_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) ();

    logic [N_REQ-1:0]       req_valid;
    logic [DIM_W*N_REQ-1:0] req_rows;
    logic [DIM_W*N_REQ-1:0] req_cols;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [1:0]             rsp_err;
    logic                   eng_clr;
    logic [DIM_W-1:0]       eng_rows;
    logic [DIM_W-1:0]       eng_cols;
    logic                   eng_done;
    logic                   busy;

    modport master (
        output req_valid, req_rows, req_cols, rsp_ready, eng_done,
        input  req_ready, rsp_valid, rsp_err, eng_clr, eng_rows, eng_cols, busy
    );

    modport slave (
        input  req_valid, req_rows, req_cols, rsp_ready, eng_done,
        output req_ready, rsp_valid, rsp_err, eng_clr, eng_rows, eng_cols, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             found
);

    int unsigned j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(ptr) + i) % N_REQ;
            if (!found && req[IW'(j)]) begin
                found          = 1'b1;
                grant[IW'(j)]  = 1'b1;
                grant_idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/conv_job_sched.sv
// Shares one 3x3 convolution engine between N_REQ requesters, one job at a time,
// with dimension checking and a run timeout.
module conv_job_sched
    import conv_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned MAX_DIM = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    conv_job_sched_if.slave bus
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    // The counter reaches TIMEOUT on the edge that ends the last allowed RUN cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             any_req;
    logic [IW-1:0]    rr_ptr_q, owner_q, ptr_next;
    logic [DIM_W-1:0] rows_q, cols_q, sel_rows, sel_cols;
    logic [1:0]       err_q;
    logic [CW-1:0]    cnt_q;
    logic             sel_legal, done_now, tmo_now, rsp_ack;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (any_req)
    );

    assign sel_rows  = bus.req_rows[DIM_W*grant_idx +: DIM_W];
    assign sel_cols  = bus.req_cols[DIM_W*grant_idx +: DIM_W];
    assign sel_legal = dim_legal(sel_rows, MAX_DIM) && dim_legal(sel_cols, MAX_DIM);
    assign ptr_next  = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IW'(1);
    assign done_now  = (state_q == StRun) && bus.eng_done;
    assign tmo_now   = (state_q == StRun) && (cnt_q == CNT_LAST);
    assign rsp_ack   = (state_q == StResp) && bus.rsp_ready[owner_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = sel_legal ? StClear : StResp;
            StClear: state_d = StRun;
            StRun:   if (done_now || tmo_now) state_d = StResp;
            StResp:  if (rsp_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
        end else begin
            if (state_q == StIdle && any_req) begin
                rr_ptr_q <= ptr_next;
                owner_q  <= grant_idx;
                rows_q   <= sel_rows;
                cols_q   <= sel_cols;
                err_q    <= sel_legal ? ERR_OK : ERR_DIM;
            end
            if (state_q == StRun) begin
                cnt_q <= cnt_q + CW'(1);
                // Done takes priority over a coincident timeout.
                if (done_now) begin
                    err_q <= ERR_OK;
                end else if (tmo_now) begin
                    err_q <= ERR_TMO;
                end
            end
            if (rsp_ack) begin
                cnt_q <= '0;
            end
        end
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle) ? grant : '0;
        bus.rsp_valid = '0;
        if (state_q == StResp) begin
            bus.rsp_valid[owner_q] = 1'b1;
        end
        bus.rsp_err  = err_q;
        bus.eng_clr  = (state_q != StRun);
        bus.eng_rows = rows_q;
        bus.eng_cols = cols_q;
        bus.busy     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_conv_job_sched.sv
// Directed bench for conv_job_sched with a simple engine model that raises done
// in its run_len-th cycle out of clear (run_len = 0: never).
module tb_conv_job_sched;
    import conv_pkg::*;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   run_len = 0;
    int   ecnt;

    conv_job_sched_if #(.N_REQ(2)) bus ();

    conv_job_sched #(.N_REQ(2), .MAX_DIM(8), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.eng_clr) ecnt <= 0;
        else                    ecnt <= ecnt + 1;
    end
    assign bus.eng_done = !bus.eng_clr && (run_len != 0) && (ecnt == run_len - 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [3:0] rows, input logic [3:0] cols);
        bus.req_rows[4*idx +: 4] = rows;
        bus.req_cols[4*idx +: 4] = cols;
    endtask

    // Ticks until a response appears, counting cycles with the engine released.
    task automatic wait_rsp(output int low, output bit to);
        low = 0;
        to  = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (bus.rsp_valid != 2'b00) break;
            tick();
            if (!bus.eng_clr) low++;
        end
        if (bus.rsp_valid != 2'b00) to = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.eng_clr !== 1'b1) begin fails++; $display("FAIL reset_eng_clr: got %b want 1", bus.eng_clr); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
        tests++; if (bus.rsp_err !== 2'b00) begin fails++; $display("FAIL reset_rsp_err: got %b want 00", bus.rsp_err); end
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        tests++; if ({bus.eng_rows, bus.eng_cols} !== 8'h00) begin
            fails++; $display("FAIL reset_eng_dims: got %h want 00", {bus.eng_rows, bus.eng_cols}); end
        #17 rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int low; bit to;
        run_len = 9;
        set_req(0, 4'd5, 4'd5);
        bus.req_valid = 2'b01;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_req_ready: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        tests++; if (bus.eng_clr !== 1'b1 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL single_clear: got clr=%b busy=%b want 1 1", bus.eng_clr, bus.busy); end
        tests++; if ({bus.eng_rows, bus.eng_cols} !== 8'h55) begin
            fails++; $display("FAIL single_eng_dims: got %h want 55", {bus.eng_rows, bus.eng_cols}); end
        wait_rsp(low, to);
        tests++; if (to || low != 9) begin fails++; $display("FAIL single_run_len: got %0d (to=%b) want 9", low, to); end
        tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 2'b00) begin
            fails++; $display("FAIL single_rsp: got v=%b e=%b want 01 00", bus.rsp_valid, bus.rsp_err); end
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_alternate();
        int low; bit to;
        logic [1:0] exp;
        tick();
        rst = 1'b1;
        #4 rst = 1'b0;
        tick();
        run_len = 1;
        set_req(0, 4'd3, 4'd3);
        set_req(1, 4'd3, 4'd3);
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (bus.req_ready !== exp) begin
                fails++; $display("FAIL alt_grant%0d: got %b want %b", k, bus.req_ready, exp); end
            tick();
            wait_rsp(low, to);
            tests++; if (to || bus.rsp_valid !== exp || bus.rsp_err !== 2'b00) begin
                fails++; $display("FAIL alt_rsp%0d: got v=%b e=%b want %b 00", k, bus.rsp_valid, bus.rsp_err, exp); end
            bus.rsp_ready = exp;
            tick();
            bus.rsp_ready = 2'b00;
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_bad_dims();
        bit dropped = 1'b0;
        set_req(1, 4'd2, 4'd9);
        bus.req_valid = 2'b10;
        #1;
        tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL bad_req_ready: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        if (bus.eng_clr !== 1'b1) dropped = 1'b1;
        tests++; if (bus.rsp_valid !== 2'b10 || bus.rsp_err !== 2'b01) begin
            fails++; $display("FAIL bad_rsp: got v=%b e=%b want 10 01", bus.rsp_valid, bus.rsp_err); end
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = 2'b00;
        if (bus.eng_clr !== 1'b1) dropped = 1'b1;
        tests++; if (dropped) begin fails++; $display("FAIL bad_eng_clr: got drop=1 want 0"); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL bad_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        int low; bit to;
        run_len = 0;
        set_req(0, 4'd8, 4'd8);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(low, to);
        tests++; if (to || low != 255) begin fails++; $display("FAIL tmo_run_len: got %0d (to=%b) want 255", low, to); end
        tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 2'b10) begin
            fails++; $display("FAIL tmo_rsp: got v=%b e=%b want 01 10", bus.rsp_valid, bus.rsp_err); end
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        run_len = 9;
        set_req(0, 4'd5, 4'd5);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(low, to);
        tests++; if (to || low != 9 || bus.rsp_err !== 2'b00) begin
            fails++; $display("FAIL tmo_next_job: got len=%0d e=%b want 9 00", low, bus.rsp_err); end
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_tie();
        int low; bit to;
        bit held = 1'b1;
        bit blocked = 1'b1;
        run_len = 255;
        set_req(1, 4'd4, 4'd4);
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(low, to);
        tests++; if (to || low != 255 || bus.rsp_err !== 2'b00) begin
            fails++; $display("FAIL tie_done_wins: got len=%0d e=%b want 255 00", low, bus.rsp_err); end
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b01;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.rsp_valid !== 2'b10) held = 1'b0;
            if (bus.req_ready !== 2'b00) blocked = 1'b0;
        end
        tests++; if (!held) begin fails++; $display("FAIL tie_rsp_hold: got rsp_valid=%b want 10 throughout", bus.rsp_valid); end
        tests++; if (!blocked) begin fails++; $display("FAIL tie_req_blocked: got req_ready=%b want 00 throughout", bus.req_ready); end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = 2'b00;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL tie_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        run_len = 0;
        set_req(0, 4'd6, 4'd6);
        set_req(1, 4'd6, 4'd6);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        tests++; if (bus.eng_clr !== 1'b0) begin fails++; $display("FAIL rstmid_running: got clr=%b want 0", bus.eng_clr); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.eng_clr !== 1'b1 || bus.rsp_valid !== 2'b00) begin
            fails++; $display("FAIL rstmid_clear: got busy=%b clr=%b v=%b want 0 1 00",
                              bus.busy, bus.eng_clr, bus.rsp_valid); end
        #10 rst = 1'b0;
        tick();
        bus.req_valid = 2'b11;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL rstmid_ptr: got req_ready=%b want 01", bus.req_ready); end
        bus.req_valid = 2'b00;
        tick();
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_rows  = '0;
        bus.req_cols  = '0;
        bus.rsp_ready = 2'b00;
        test_reset();
        test_single();
        test_alternate();
        test_bad_dims();
        test_timeout();
        test_tie();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
